gmii_rx_cdc_fifo: RTL and testbench

- Dual-clock byte FIFO carrying GMII receive data from the PHY receive clock domain (wclk) into the switch clock domain (switch_clk).
- Contains a reset synchronizer that brings switch_rst_n into the wclk domain.
- Contains a Gray-coded asynchronous FIFO with registered read data.
- Sits between the GMII pins and the RX MAC parser.

---
 rtl/gmii_rx_cdc_fifo.sv | 194 +++++++++++++++++++
 tb/tb_gmii_rx_cdc_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_cdc_fifo.sv
// ---------------------------------------------------------------------------
// gmii_rx_cdc_fifo
//
// Dual-clock byte FIFO that carries GMII receive data from the PHY receive
// clock (wclk) into the switch clock domain (switch_clk), ahead of the RX MAC
// parser. It uses Gray-coded pointers and has registered read data. It also
// contains the reset synchronizer that produces the write-domain reset from
// switch_rst_n.
//
// Optional build macro: CDC_FIFO_STATS_EN
//   defined   -> saturating overflow/underflow event counters are built.
//   undefined -> both counter outputs are tied to 0 and no counter flops exist.
//
// Ports
//   switch_clk       in   read-side clock
//   switch_rst_n     in   async active-low reset, switch_clk domain
//   wclk             in   write-side clock (GMII RX clock)
//   w_en             in   write request (source qualifies with dv && !er)
//   w_data           in   write data, DATA_WIDTH bits
//   w_full           out  FIFO full, wclk domain (registered)
//   r_en             in   read request, switch_clk domain
//   r_data           out  read data, registered, valid one cycle after r_en
//   r_empty          out  FIFO empty, switch_clk domain (registered)
//   wrst_n_sync      out  switch_rst_n synchronized to wclk
//   overflow_count   out  writes rejected while full (wclk domain)
//   underflow_count  out  reads rejected while empty (switch_clk domain)
//
// Requires ADDR_WIDTH >= 2 and SYNC_STAGES >= 2.
// ---------------------------------------------------------------------------
module gmii_rx_cdc_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  switch_clk,
  input  logic                  switch_rst_n,
  input  logic                  wclk,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  w_full,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_empty,
  output logic                  wrst_n_sync,
  output logic [31:0]           overflow_count,
  output logic [31:0]           underflow_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;   // pointer width, extra MSB for wrap

  // -------------------------------------------------------------------------
  // Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES
  // wclk edges by shifting in a constant 1.
  // -------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_wrst_chain;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours; blocking here would collapse
  // the synchronizer chain into a single stage.
  always_ff @(posedge wclk or negedge switch_rst_n) begin
    if (!switch_rst_n) r_wrst_chain <= '0;
    else               r_wrst_chain <= {r_wrst_chain[SYNC_STAGES-2:0], 1'b1};
  end

  assign wrst_n_sync = r_wrst_chain[SYNC_STAGES-1];

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // -------------------------------------------------------------------------
  // Write domain
  // -------------------------------------------------------------------------
  logic [PW-1:0]                  r_wbin;
  logic [PW-1:0]                  r_wgray;
  logic                           r_w_full;
  logic [SYNC_STAGES-1:0][PW-1:0] r_rgray_sync;   // [SYNC_STAGES-1] is the output
  logic [PW-1:0]                  w_wbin_next;
  logic [PW-1:0]                  w_wgray_next;
  logic [PW-1:0]                  w_rgray_in_w;
  logic                           w_full_next;
  logic                           w_do_write;

  assign w_rgray_in_w = r_rgray_sync[SYNC_STAGES-1];
  // Writes are gated by the local reset so nothing lands while it is held.
  assign w_do_write   = w_en && !r_w_full && wrst_n_sync;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch can be inferred.
  always_comb begin
    w_wbin_next  = r_wbin;
    if (w_do_write) w_wbin_next = r_wbin + 1'b1;
    w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    // Full when the write pointer is one lap ahead of the read pointer. In Gray
    // code, that is the top two bits inverted and the rest equal.
    w_full_next  = (w_wgray_next == {~w_rgray_in_w[PW-1:PW-2], w_rgray_in_w[PW-3:0]});
  end

  always_ff @(posedge wclk or negedge wrst_n_sync) begin
    if (!wrst_n_sync) begin
      r_wbin       <= '0;
      r_wgray      <= '0;
      r_w_full     <= 1'b0;
      r_rgray_sync <= '0;
    end else begin
      r_wbin       <= w_wbin_next;
      r_wgray      <= w_wgray_next;
      r_w_full     <= w_full_next;
      r_rgray_sync <= {r_rgray_sync[SYNC_STAGES-2:0], r_rgray_local_q()};
    end
  end

  // NOTE: the storage array has no reset. Its contents are only ever read
  // behind a valid pointer, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge wclk) begin
    if (w_do_write) r_mem[r_wbin[ADDR_WIDTH-1:0]] <= w_data;
  end

  assign w_full = r_w_full;

  // -------------------------------------------------------------------------
  // Read domain
  // -------------------------------------------------------------------------
  logic [PW-1:0]                  r_rbin;
  logic [PW-1:0]                  r_rgray;
  logic                           r_r_empty;
  logic [DATA_WIDTH-1:0]          r_rdata;
  logic [SYNC_STAGES-1:0][PW-1:0] r_wgray_sync;
  logic [PW-1:0]                  w_rbin_next;
  logic [PW-1:0]                  w_rgray_next;
  logic                           w_do_read;

  // Gives the write-domain synchronizer a single named source for the read
  // Gray pointer.
  function automatic logic [PW-1:0] r_rgray_local_q();
    return r_rgray;
  endfunction

  assign w_do_read = r_en && !r_r_empty;

  always_comb begin
    w_rbin_next  = r_rbin;
    if (w_do_read) w_rbin_next = r_rbin + 1'b1;
    w_rgray_next = w_rbin_next ^ (w_rbin_next >> 1);
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) begin
      r_rbin       <= '0;
      r_rgray      <= '0;
      r_r_empty    <= 1'b1;
      r_rdata      <= '0;
      r_wgray_sync <= '0;
    end else begin
      r_rbin       <= w_rbin_next;
      r_rgray      <= w_rgray_next;
      r_r_empty    <= (w_rgray_next == r_wgray_sync[SYNC_STAGES-1]);
      r_wgray_sync <= {r_wgray_sync[SYNC_STAGES-2:0], r_wgray};
      if (w_do_read) r_rdata <= r_mem[r_rbin[ADDR_WIDTH-1:0]];
    end
  end

  assign r_data  = r_rdata;
  assign r_empty = r_r_empty;

  // -------------------------------------------------------------------------
  // Optional saturating event counters
  // -------------------------------------------------------------------------
`ifdef CDC_FIFO_STATS_EN
  logic [31:0] r_overflow_count;
  logic [31:0] r_underflow_count;

  always_ff @(posedge wclk or negedge wrst_n_sync) begin
    if (!wrst_n_sync) r_overflow_count <= '0;
    else if (w_en && r_w_full && (r_overflow_count != 32'hFFFF_FFFF))
      r_overflow_count <= r_overflow_count + 32'd1;
  end

  always_ff @(posedge switch_clk or negedge switch_rst_n) begin
    if (!switch_rst_n) r_underflow_count <= '0;
    else if (r_en && r_r_empty && (r_underflow_count != 32'hFFFF_FFFF))
      r_underflow_count <= r_underflow_count + 32'd1;
  end

  assign overflow_count  = r_overflow_count;
  assign underflow_count = r_underflow_count;
`else
  assign overflow_count  = 32'd0;
  assign underflow_count = 32'd0;
`endif

endmodule

// File: tb/tb_gmii_rx_cdc_fifo.sv
// ---------------------------------------------------------------------------
// tb_gmii_rx_cdc_fifo
//
// Directed bench for gmii_rx_cdc_fifo. Write clock : switch clock = 8 : 5 in
// period, matching 125 MHz : 200 MHz. Rising edges of the two clocks are
// always at least 5 time units apart, so sampling 1 unit after an edge never
// races the other clock.
// ---------------------------------------------------------------------------
module tb_gmii_rx_cdc_fifo;

  localparam int SYNC_STAGES = 2;
`ifdef CDC_FIFO_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        switch_clk = 1'b0;
  logic        switch_rst_n;
  logic        wclk = 1'b0;
  logic        w_en;
  logic [7:0]  w_data;
  logic        w_full;
  logic        r_en;
  logic [7:0]  r_data;
  logic        r_empty;
  logic        wrst_n_sync;
  logic [31:0] overflow_count;
  logic [31:0] underflow_count;

  int total = 0;
  int bad   = 0;

  gmii_rx_cdc_fifo #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (4),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .switch_clk     (switch_clk),
    .switch_rst_n   (switch_rst_n),
    .wclk           (wclk),
    .w_en           (w_en),
    .w_data         (w_data),
    .w_full         (w_full),
    .r_en           (r_en),
    .r_data         (r_data),
    .r_empty        (r_empty),
    .wrst_n_sync    (wrst_n_sync),
    .overflow_count (overflow_count),
    .underflow_count(underflow_count)
  );

  always #40 wclk       = ~wclk;        // period 80
  always #25 switch_clk = ~switch_clk;  // period 50

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    w_en   = 1'b1;
    w_data = d;
    @(posedge wclk);
    #1;
    w_en   = 1'b0;
  endtask

  task automatic pop(input logic [7:0] exp, input string tag);
    int k = 0;
    while (r_empty && k < 200) begin
      @(posedge switch_clk);
      #1;
      k++;
    end
    check({tag, " avail"}, r_empty, 1'b0);
    r_en = 1'b1;
    @(posedge switch_clk);
    #1;
    r_en = 1'b0;
    check(tag, r_data, exp);
  endtask

  logic [7:0] seq [24];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    switch_rst_n = 1'b0;
    w_en   = 1'b0;
    w_data = 8'h00;
    r_en   = 1'b0;

    // ---------------- Reset release ----------------
    repeat (5) @(posedge switch_clk);
    #1;
    check("rst r_empty", r_empty, 1'b1);
    check("rst w_full", w_full, 1'b0);
    check("rst r_data", r_data, 8'h00);
    check("rst wrst_n_sync low", wrst_n_sync, 1'b0);
    switch_rst_n = 1'b1;
    @(posedge wclk); #1;
    check("wrst after 1 edge", wrst_n_sync, 1'b0);
    @(posedge wclk); #1;
    check("wrst after 2 edges", wrst_n_sync, 1'b1);
    check("post-rst r_empty", r_empty, 1'b1);
    check("post-rst w_full", w_full, 1'b0);

    // ---------------- Basic transfer ----------------
    for (int i = 0; i < 7; i++) seq[i] = 8'h55;
    seq[7] = 8'hD5;
    for (int i = 0; i < 16; i++) seq[8+i] = 8'(i + 1);

    push(seq[0]);
    k = 0;
    while (r_empty && k < 20) begin
      @(posedge switch_clk); #1;
      k++;
    end
    check("empty fall latency", k, SYNC_STAGES + 1);

    fork
      begin
        for (int i = 1; i < 24; i++) push(seq[i]);
      end
      begin
        for (int i = 0; i < 24; i++) pop(seq[i], $sformatf("basic[%0d]", i));
      end
    join
    check("basic w_full", w_full, 1'b0);

    // ---------------- Full boundary ----------------
    repeat (6) @(posedge wclk);
    #1;
    for (int i = 0; i < 20; i++) begin
      push(8'(i));
      if (i == 14) check("full after 15", w_full, 1'b0);
      if (i == 15) check("full after 16", w_full, 1'b1);
    end
    check("full held", w_full, 1'b1);
    check("overflow_count", overflow_count, STATS ? 32'd4 : 32'd0);
    repeat (6) @(posedge switch_clk);
    #1;
    for (int i = 0; i < 16; i++) pop(8'(i), $sformatf("full rd[%0d]", i));
    check("drained r_empty", r_empty, 1'b1);
    check("no underflow yet", underflow_count, 32'd0);

    // ---------------- Underflow ----------------
    r_en = 1'b1;
    repeat (3) @(posedge switch_clk);
    #1;
    r_en = 1'b0;
    check("uflow r_data held", r_data, 8'h0F);
    check("uflow r_empty", r_empty, 1'b1);
    check("underflow_count", underflow_count, STATS ? 32'd3 : 32'd0);
    // An unchanged read pointer means the next byte written is the next read.
    push(8'h77);
    pop(8'h77, "uflow rbin intact");
    repeat (6) @(posedge wclk);
    #1;
    check("w_full cleared", w_full, 1'b0);

    // ---------------- Wrap-around ----------------
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 12; i++) push(8'(r * 12 + i + 8'h30));
      check($sformatf("wrap full r%0d", r), w_full, 1'b0);
      for (int i = 0; i < 12; i++) pop(8'(r * 12 + i + 8'h30), $sformatf("wrap r%0d[%0d]", r, i));
      check($sformatf("wrap empty r%0d", r), r_empty, 1'b1);
      repeat (5) @(posedge wclk);
      #1;
    end

    // ---------------- Mid-stream reset ----------------
    for (int i = 0; i < 8; i++) push(8'(8'hC0 + i));
    repeat (6) @(posedge switch_clk);
    #1;
    check("queued r_empty", r_empty, 1'b0);
    switch_rst_n = 1'b0;
    #1;
    check("midrst r_empty", r_empty, 1'b1);
    check("midrst w_full", w_full, 1'b0);
    check("midrst wrst_n_sync", wrst_n_sync, 1'b0);
    check("midrst r_data", r_data, 8'h00);
    @(posedge switch_clk); #1;
    switch_rst_n = 1'b1;
    k = 0;
    while (!wrst_n_sync && k < 20) begin
      @(posedge wclk); #1;
      k++;
    end
    check("midrst wrst release", wrst_n_sync, 1'b1);
    repeat (6) @(posedge switch_clk);
    #1;
    check("midrst stays empty", r_empty, 1'b1);
    check("midrst ocount", overflow_count, 32'd0);
    check("midrst ucount", underflow_count, 32'd0);
    @(posedge wclk); #1;
    push(8'hAA);
    pop(8'hAA, "midrst first byte");
    repeat (6) @(posedge switch_clk);
    #1;
    check("midrst final empty", r_empty, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
